// File: rtl/systimer_ctrl_master.sv
// Hardware master for the systimer interval timer: programs the period, runs the
// timer in continuous mode, acks each timeout as a tick, and captures counter snapshots.
module systimer_ctrl_master #(
  parameter logic [31:0] DEFAULT_PERIOD = 32'd39999,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] cfg_period,
  input  logic        cfg_load,
  input  logic        snap_req,
  output logic [31:0] snap_value,
  output logic        snap_valid,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic        running,
  output logic        busy,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  input  logic        irq
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_PL, S_INIT_PH, S_INIT_CTRL, S_RUN, S_ACK, S_STOP_W,
    S_SNAP_W, S_SNAP_RL, S_SNAP_RH, S_SNAP_DONE
  } state_t;

  localparam state_t RESET_STATE = AUTO_START ? S_INIT_PL : S_IDLE;

  state_t      state, state_nxt;
  logic [31:0] period;
  logic        load_pend;
  logic [31:0] snap_q;
  logic        cs_c, wn_c;
  logic [2:0]  addr_c;
  logic [15:0] wd_c;
  logic        in_run, pend_win, load_take, stop_take;

  assign in_run    = (state == S_RUN);
  assign pend_win  = (state == S_ACK) || (state == S_SNAP_W) || (state == S_SNAP_RL) ||
                     (state == S_SNAP_RH) || (state == S_SNAP_DONE);
  assign stop_take = in_run && !irq && stop;
  assign load_take = in_run && !irq && !stop && (cfg_load || load_pend);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= RESET_STATE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_INIT_PL;
      S_INIT_PL:   state_nxt = S_INIT_PH;
      S_INIT_PH:   state_nxt = S_INIT_CTRL;
      S_INIT_CTRL: state_nxt = S_RUN;
      S_RUN: begin
        if (irq)                        state_nxt = S_ACK;
        else if (stop)                  state_nxt = S_STOP_W;
        else if (cfg_load || load_pend) state_nxt = S_INIT_PL;
        else if (snap_req)              state_nxt = S_SNAP_W;
      end
      S_ACK:       state_nxt = S_RUN;
      S_STOP_W:    state_nxt = S_IDLE;
      S_SNAP_W:    state_nxt = S_SNAP_RL;
      S_SNAP_RL:   state_nxt = S_SNAP_RH;
      S_SNAP_RH:   state_nxt = S_SNAP_DONE;
      S_SNAP_DONE: state_nxt = S_RUN;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // One bus access per state; reads are issued in SNAP_RL/SNAP_RH.
  always_comb begin
    cs_c   = 1'b0;
    wn_c   = 1'b1;
    addr_c = 3'd0;
    wd_c   = 16'h0000;
    case (state)
      S_INIT_PL:   begin cs_c = 1'b1; wn_c = 1'b0; addr_c = 3'd2; wd_c = period[15:0];  end
      S_INIT_PH:   begin cs_c = 1'b1; wn_c = 1'b0; addr_c = 3'd3; wd_c = period[31:16]; end
      S_INIT_CTRL: begin cs_c = 1'b1; wn_c = 1'b0; addr_c = 3'd1; wd_c = 16'h0007;      end
      S_ACK:       begin cs_c = 1'b1; wn_c = 1'b0; addr_c = 3'd0;                       end
      S_STOP_W:    begin cs_c = 1'b1; wn_c = 1'b0; addr_c = 3'd1; wd_c = 16'h0008;      end
      S_SNAP_W:    begin cs_c = 1'b1; wn_c = 1'b0; addr_c = 3'd4;                       end
      S_SNAP_RL:   begin cs_c = 1'b1;              addr_c = 3'd4;                       end
      S_SNAP_RH:   begin cs_c = 1'b1;              addr_c = 3'd5;                       end
      default: ;
    endcase
  end

  // Reset state may already be INIT_PL, so outputs are forced idle while reset is held.
  assign avm_chipselect = reset_n & cs_c;
  assign avm_write_n    = ~reset_n | wn_c;
  assign avm_address    = reset_n ? addr_c : 3'd0;
  assign avm_writedata  = reset_n ? wd_c : 16'h0000;
  assign tick           = reset_n && (state == S_ACK);
  assign snap_valid     = reset_n && (state == S_SNAP_DONE);
  assign running        = reset_n && (in_run || (state == S_STOP_W) || pend_win);
  assign busy           = reset_n && !in_run && (state != S_IDLE);
  assign snap_value     = snap_valid ? {avm_readdata, snap_q[15:0]} : snap_q;

  // A load preempted by irq, or arriving during ACK/snapshot, is kept until back in RUN.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      period     <= DEFAULT_PERIOD;
      load_pend  <= 1'b0;
      tick_count <= 32'd0;
      snap_q     <= 32'd0;
    end else begin
      if (cfg_load && ((state == S_IDLE) || pend_win || (in_run && (irq || !stop))))
        period <= cfg_period;
      if (cfg_load && (pend_win || (in_run && irq))) load_pend <= 1'b1;
      else if (load_take || stop_take)                load_pend <= 1'b0;
      if (state == S_ACK)       tick_count    <= tick_count + 32'd1;
      if (state == S_SNAP_RH)   snap_q[15:0]  <= avm_readdata;
      if (state == S_SNAP_DONE) snap_q[31:16] <= avm_readdata;
    end

endmodule
